// File: rtl/pipeline_destination_tracker_if.sv
// Bundle of ID-stage inputs, hazard controls and EX/MEM/WB tracking outputs
// exchanged between the hazard/forwarding logic (master) and the tracker (slave).
interface pipeline_destination_tracker_if #(
    parameter int REG_ADDR_W  = 5,
    parameter int STALL_CNT_W = 16
);
    logic [REG_ADDR_W-1:0]  id_destination;
    logic                   id_rf_enable;
    logic                   id_load_instruction;
    logic                   id_valid;
    logic                   load_enable;
    logic                   nop_signal;
    logic                   flush;

    logic [REG_ADDR_W-1:0]  ex_destination;
    logic [REG_ADDR_W-1:0]  mem_destination;
    logic [REG_ADDR_W-1:0]  wb_destination;
    logic                   ex_rf_enable;
    logic                   mem_rf_enable;
    logic                   wb_rf_enable;
    logic                   ex_load_instruction;
    logic                   mem_load_instruction;
    logic [STALL_CNT_W-1:0] stall_count;
    logic [STALL_CNT_W-1:0] flush_count;
    logic                   pipe_empty;

    modport master (
        output id_destination, id_rf_enable, id_load_instruction, id_valid,
               load_enable, nop_signal, flush,
        input  ex_destination, mem_destination, wb_destination,
               ex_rf_enable, mem_rf_enable, wb_rf_enable,
               ex_load_instruction, mem_load_instruction,
               stall_count, flush_count, pipe_empty
    );

    modport slave (
        input  id_destination, id_rf_enable, id_load_instruction, id_valid,
               load_enable, nop_signal, flush,
        output ex_destination, mem_destination, wb_destination,
               ex_rf_enable, mem_rf_enable, wb_rf_enable,
               ex_load_instruction, mem_load_instruction,
               stall_count, flush_count, pipe_empty
    );
endinterface

// File: rtl/pipeline_destination_tracker.sv
// EX->MEM->WB destination tracking chain with bubble/flush insertion and
// saturating stall/flush statistics; the back end drains every cycle.
module pipeline_destination_tracker #(
    parameter int REG_ADDR_W         = 5,
    parameter bit ZERO_REG_HARDWIRED = 1'b1,
    parameter int STALL_CNT_W        = 16
) (
    input logic clk,
    input logic reset,
    pipeline_destination_tracker_if.slave bus
);
    // Handshake: the hazard unit never holds ID (load_enable=0) without also
    // injecting a bubble (nop_signal=1); the tracker tolerates it regardless.

    logic [REG_ADDR_W-1:0]  ex_dest_q, mem_dest_q, wb_dest_q;
    logic                   ex_rf_q, mem_rf_q, wb_rf_q;
    logic                   ex_ld_q, mem_ld_q;
    logic [STALL_CNT_W-1:0] stall_q, flush_q;
    logic                   empty_q;

    logic [REG_ADDR_W-1:0]  ex_dest_n;
    logic                   ex_rf_n;
    logic                   ex_ld_n;
    logic                   bubble;

    always_comb begin
        bubble    = bus.flush | bus.nop_signal | ~bus.id_valid;
        ex_dest_n = '0;
        ex_rf_n   = 1'b0;
        ex_ld_n   = 1'b0;
        if (!bubble) begin
            ex_dest_n = bus.id_destination;
            ex_rf_n   = bus.id_rf_enable &
                        ~(ZERO_REG_HARDWIRED && (bus.id_destination == '0));
            // A load that never writes (incl. to r0) cannot cause a load-use stall.
            ex_ld_n   = bus.id_load_instruction & ex_rf_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_dest_q  <= '0;
            mem_dest_q <= '0;
            wb_dest_q  <= '0;
            ex_rf_q    <= 1'b0;
            mem_rf_q   <= 1'b0;
            wb_rf_q    <= 1'b0;
            ex_ld_q    <= 1'b0;
            mem_ld_q   <= 1'b0;
            stall_q    <= '0;
            flush_q    <= '0;
            empty_q    <= 1'b1;
        end else begin
            ex_dest_q  <= ex_dest_n;
            ex_rf_q    <= ex_rf_n;
            ex_ld_q    <= ex_ld_n;
            mem_dest_q <= ex_dest_q;
            mem_rf_q   <= ex_rf_q;
            mem_ld_q   <= ex_ld_q;
            wb_dest_q  <= mem_dest_q;
            wb_rf_q    <= mem_rf_q;
            // Next-state view: new EX, new MEM (old EX), new WB (old MEM).
            empty_q    <= ~(ex_rf_n | ex_rf_q | mem_rf_q);
            if (bus.nop_signal && (stall_q != '1))
                stall_q <= stall_q + STALL_CNT_W'(1);
            if (bus.flush && bus.id_valid && (flush_q != '1))
                flush_q <= flush_q + STALL_CNT_W'(1);
        end
    end

    assign bus.ex_destination       = ex_dest_q;
    assign bus.mem_destination      = mem_dest_q;
    assign bus.wb_destination       = wb_dest_q;
    assign bus.ex_rf_enable         = ex_rf_q;
    assign bus.mem_rf_enable        = mem_rf_q;
    assign bus.wb_rf_enable         = wb_rf_q;
    assign bus.ex_load_instruction  = ex_ld_q;
    assign bus.mem_load_instruction = mem_ld_q;
    assign bus.stall_count          = stall_q;
    assign bus.flush_count          = flush_q;
    assign bus.pipe_empty           = empty_q;

    illegal_hold_check: assert property (@(posedge clk) disable iff (reset)
        !(!bus.load_enable && !bus.nop_signal));
endmodule

// File: tb/tb_pipeline_destination_tracker.sv
// Directed-vector bench: each stimulus cycle pushes its expected post-edge
// state; a monitor pops and compares after every rising edge.
module tb_pipeline_destination_tracker;
    localparam int AW  = 5;
    localparam int CW  = 16;
    localparam int SCW = 3;
    localparam int VW  = 3*AW + 5 + 2*CW + 1;

    logic clk = 1'b0;
    logic reset;

    pipeline_destination_tracker_if #(.REG_ADDR_W(AW), .STALL_CNT_W(CW))  bus ();
    pipeline_destination_tracker_if #(.REG_ADDR_W(AW), .STALL_CNT_W(SCW)) sbus ();

    pipeline_destination_tracker #(.REG_ADDR_W(AW), .ZERO_REG_HARDWIRED(1'b1), .STALL_CNT_W(CW))
        dut (.clk(clk), .reset(reset), .bus(bus.slave));
    pipeline_destination_tracker #(.REG_ADDR_W(AW), .ZERO_REG_HARDWIRED(1'b1), .STALL_CNT_W(SCW))
        dut_sat (.clk(clk), .reset(reset), .bus(sbus.slave));

    assign sbus.id_destination      = bus.id_destination;
    assign sbus.id_rf_enable        = bus.id_rf_enable;
    assign sbus.id_load_instruction = bus.id_load_instruction;
    assign sbus.id_valid            = bus.id_valid;
    assign sbus.load_enable         = bus.load_enable;
    assign sbus.nop_signal          = bus.nop_signal;
    assign sbus.flush               = bus.flush;

    always #5 clk = ~clk;

    logic [VW-1:0]  exp_q[$];
    logic [SCW-1:0] sat_q[$];
    int             tag_q[$];
    int             tests_run = 0;
    int             tests_failed = 0;
    int             vec_id = 0;

    // Vector layout: {ex_d, mem_d, wb_d, ex_rf, mem_rf, wb_rf, ex_ld, mem_ld, stall, flush, empty}
    function automatic logic [VW-1:0] pack_exp(
        input int exd, input int memd, input int wbd,
        input bit exrf, input bit memrf, input bit wbrf,
        input bit exld, input bit memld,
        input int stall, input int fcnt, input bit empty);
        return {AW'(exd), AW'(memd), AW'(wbd), exrf, memrf, wbrf, exld, memld,
                CW'(stall), CW'(fcnt), empty};
    endfunction

    task automatic step(
        input bit rst, input bit v, input int d, input bit rf, input bit ld,
        input bit le, input bit nop, input bit fl,
        input int exd, input int memd, input int wbd,
        input bit exrf, input bit memrf, input bit wbrf,
        input bit exld, input bit memld,
        input int stall, input int fcnt, input bit empty);
        @(negedge clk);
        reset                   = rst;
        bus.id_valid            = v;
        bus.id_destination      = AW'(d);
        bus.id_rf_enable        = rf;
        bus.id_load_instruction = ld;
        bus.load_enable         = le;
        bus.nop_signal          = nop;
        bus.flush               = fl;
        exp_q.push_back(pack_exp(exd, memd, wbd, exrf, memrf, wbrf, exld, memld, stall, fcnt, empty));
        sat_q.push_back((stall > 7) ? SCW'(7) : SCW'(stall));
        tag_q.push_back(vec_id);
        vec_id++;
    endtask

    // Monitor: the DUT presents a new state after every rising edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            logic [VW-1:0]  exp_v, got_v;
            logic [SCW-1:0] exp_s;
            int             tag;
            exp_v = exp_q.pop_front();
            exp_s = sat_q.pop_front();
            tag   = tag_q.pop_front();
            got_v = {bus.ex_destination, bus.mem_destination, bus.wb_destination,
                     bus.ex_rf_enable, bus.mem_rf_enable, bus.wb_rf_enable,
                     bus.ex_load_instruction, bus.mem_load_instruction,
                     bus.stall_count, bus.flush_count, bus.pipe_empty};
            tests_run++;
            if (got_v !== exp_v) begin
                tests_failed++;
                $display("FAIL vec%0d state: got=%h expected=%h", tag, got_v, exp_v);
            end
            tests_run++;
            if (sbus.stall_count !== exp_s) begin
                tests_failed++;
                $display("FAIL vec%0d sat_stall_count: got=%0d expected=%0d", tag, sbus.stall_count, exp_s);
            end
        end
    end

    initial begin
        reset = 1'b1;
        bus.id_valid = 1'b0; bus.id_destination = '0; bus.id_rf_enable = 1'b0;
        bus.id_load_instruction = 1'b0; bus.load_enable = 1'b1;
        bus.nop_signal = 1'b0; bus.flush = 1'b0;

        //   rst v  d  rf ld le nop fl | exd memd wbd exrf memrf wbrf exld memld stall fcnt empty
        // Reset held with a live instruction in ID
        step(1, 1, 7, 1, 0, 1, 0, 0,   0, 0, 0,   0, 0, 0, 0, 0,   0, 0, 1);
        step(1, 1, 7, 1, 0, 1, 0, 0,   0, 0, 0,   0, 0, 0, 0, 0,   0, 0, 1);
        step(0, 1, 7, 1, 0, 1, 0, 0,   7, 0, 0,   1, 0, 0, 0, 0,   0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0,   0, 7, 0,   0, 1, 0, 0, 0,   0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 7,   0, 0, 1, 0, 0,   0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0,   0, 0, 0, 0, 0,   0, 0, 1);
        // Straight flow 3,4,5 then drain
        step(0, 1, 3, 1, 0, 1, 0, 0,   3, 0, 0,   1, 0, 0, 0, 0,   0, 0, 0);
        step(0, 1, 4, 1, 0, 1, 0, 0,   4, 3, 0,   1, 1, 0, 0, 0,   0, 0, 0);
        step(0, 1, 5, 1, 0, 1, 0, 0,   5, 4, 3,   1, 1, 1, 0, 0,   0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0,   0, 5, 4,   0, 1, 1, 0, 0,   0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 5,   0, 0, 1, 0, 0,   0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0,   0, 0, 0, 0, 0,   0, 0, 1);
        // Load-use: load r8, one bubble, then the dependent instruction issues
        step(0, 1, 8, 1, 1, 1, 0, 0,   8, 0, 0,   1, 0, 0, 1, 0,   0, 0, 0);
        step(0, 1, 10,1, 0, 0, 1, 0,   0, 8, 0,   0, 1, 0, 0, 1,   1, 0, 0);
        step(0, 1, 10,1, 0, 1, 0, 0,  10, 0, 8,   1, 0, 1, 0, 0,   1, 0, 0);
        // Flush together with nop: single bubble, both counters step
        step(0, 1, 9, 1, 0, 0, 1, 1,   0, 10, 0,  0, 1, 0, 0, 0,   2, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 10,  0, 0, 1, 0, 0,   2, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0,   0, 0, 0, 0, 0,   2, 1, 1);
        // Load to r0 is neither a write nor a load
        step(0, 1, 0, 1, 1, 1, 0, 0,   0, 0, 0,   0, 0, 0, 0, 0,   2, 1, 1);
        // Flush with empty ID is not counted; flush with a real instruction is
        step(0, 0, 0, 0, 0, 1, 0, 1,   0, 0, 0,   0, 0, 0, 0, 0,   2, 1, 1);
        step(0, 1, 6, 1, 0, 1, 0, 1,   0, 0, 0,   0, 0, 0, 0, 0,   2, 2, 1);
        // Non-writing load keeps its destination but drops the load flag
        step(0, 1, 12,0, 1, 1, 0, 0,  12, 0, 0,   0, 0, 0, 0, 0,   2, 2, 1);
        step(0, 0, 0, 0, 0, 1, 0, 0,   0, 12, 0,  0, 0, 0, 0, 0,   2, 2, 1);
        // Ten nop cycles: the 3-bit counter saturates at 7
        for (int i = 0; i < 10; i++)
            step(0, 0, 0, 0, 0, 0, 1, 0,   0, 0, (i == 0) ? 12 : 0,   0, 0, 0, 0, 0,   3 + i, 2, 1);
        // Reset mid-stream clears both counters
        step(1, 1, 5, 1, 0, 1, 1, 0,   0, 0, 0,   0, 0, 0, 0, 0,   0, 0, 1);
        step(0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0,   0, 0, 0, 0, 0,   0, 0, 1);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #3;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain: got=%0d pending expected=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
